clock_gen: RTL and testbench
============================

CLOCK_GEN -- requirements
Module: clock_gen

Interface
REQ-001 Parameter PERIOD, default 10: output period in reference clock cycles; legal range 2..65535.
REQ-002 Parameter DUTY, default 50: high time as an integer percent of the period; legal range 1..99.
REQ-003 Parameter PHASE, default 0: idle reference cycles inserted before the first period after each start; legal range 0..65535.
REQ-004 Port clk, input, 1 bit: reference clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port enable, input, 1 bit: run request; asynchronous to clk.
REQ-007 Port clk_out, output, 1 bit: generated clock, registered, glitch-free.
REQ-008 Port running, output, 1 bit: high while the generator is in the PHASE wait or producing periods.
REQ-009 Port period_start, output, 1 bit: one-cycle pulse coincident with the first high cycle of every period.

Function
REQ-010 enable SHALL pass through a 2-flop synchronizer (en_s) before use; no other logic samples raw enable.
REQ-011 HIGH SHALL equal round-half-up(PERIOD*DUTY/100), clamped to 1..PERIOD-1, computed at elaboration.
REQ-012 States SHALL be IDLE, WAIT, RUN and (macro only) DRAIN.
REQ-013 IDLE->WAIT when en_s=1 and PHASE>0; IDLE->RUN when en_s=1 and PHASE=0.
REQ-014 WAIT SHALL count exactly PHASE cycles with clk_out=0, then enter RUN.
REQ-015 In RUN, cnt SHALL count 0..PERIOD-1 and wrap to 0; clk_out=1 for cnt<HIGH, else 0.
REQ-016 With enable rising sampled at clk edge N and PHASE=0, clk_out SHALL first be high after edge N+2.
REQ-017 period_start SHALL be 1 exactly in the cycles where clk_out=1 and cnt=0.
REQ-018 running SHALL be 1 in WAIT, RUN and DRAIN, and 0 in IDLE.
REQ-019 Width rule: cnt SHALL be wide enough for max(PERIOD, PHASE)-1; no overflow at the upper legal bounds.
REQ-020 An en_s re-assertion during WAIT SHALL NOT restart the phase count.

Reset
REQ-021 While rst=1 (asynchronous), clk_out=0, running=0, period_start=0, cnt=0, synchronizer flops=0 and state=IDLE.
REQ-022 Reset asserted mid-period SHALL drop clk_out to 0 immediately with no partial pulse afterwards.
REQ-023 After rst is released, operation SHALL restart from IDLE, including any PHASE wait.

Configuration
REQ-024 Macro CLOCK_GEN_GLITCHFREE_EN defined: en_s falling in RUN SHALL enter DRAIN.
REQ-025 In DRAIN the current period SHALL complete in full, then the block returns to IDLE with cnt=0.
REQ-026 In DRAIN, en_s rising before the period ends SHALL return to RUN seamlessly, with no phase wait and no shortened period.
REQ-027 Macro undefined: en_s falling in WAIT or RUN SHALL force clk_out=0, cnt=0 and state=IDLE on the next edge, truncating the period.
REQ-028 With either macro setting, en_s falling in WAIT SHALL return the block to IDLE on the next edge.

Verification
REQ-029 PERIOD=10, DUTY=50, PHASE=0, enable held high -> clk_out repeats 5 high / 5 low; period_start every 10 cycles.
REQ-030 PERIOD=8, DUTY=25 -> HIGH=2; PERIOD=8, DUTY=90 -> HIGH=7; PERIOD=4, DUTY=10 -> HIGH=1 (clamped); PERIOD=4, DUTY=99 -> HIGH=3 (clamped).
REQ-031 PHASE=3, enable rising sampled at edge N -> running=1 after edge N+2 and clk_out first high after edge N+5.
REQ-032 Macro defined, PERIOD=10, enable dropped at cnt=2 -> 5 high / 5 low completes, then IDLE; re-enable at cnt=7 -> next period starts on schedule.
REQ-033 Macro undefined, enable dropped at cnt=2 -> clk_out=0 within 3 edges of the drop and running=0.
REQ-034 rst pulsed mid-high phase -> clk_out=0 asynchronously; 10 random enable toggles at random 0-255-cycle delays -> no clk_out pulse is shorter than HIGH (macro defined).

Source files
------------

// File: rtl/clock_gen.sv
// ============================================================================
// Module   : clock_gen
// Purpose  : Derives a registered, glitch-free divided clock from the
//            reference clock. The output has a fixed period of PERIOD
//            reference cycles and a high time of HIGH cycles. HIGH is the
//            nearest whole number to PERIOD*DUTY/100 (halves round up),
//            clamped to 1..PERIOD-1. An optional PHASE delay of idle
//            reference cycles precedes the first period after each start.
// Ports    : clk          in  reference clock, rising-edge active
//            rst          in  asynchronous reset, active high
//            enable       in  run request, asynchronous to clk
//            clk_out      out generated clock (registered)
//            running      out high while waiting out PHASE or producing
//                             periods (and while draining)
//            period_start out one-cycle pulse on the first high cycle of
//                             each period
// Config   : CLOCK_GEN_GLITCHFREE_EN - when defined, dropping enable while
//            periods are being produced lets the current period finish in
//            full (DRAIN state). When undefined, the period is cut short on
//            the next edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_gen #(
  parameter int PERIOD = 10,  // 2..65535
  parameter int DUTY   = 50,  // 1..99 percent
  parameter int PHASE  = 0    // 0..65535
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic clk_out,
  output logic running,
  output logic period_start
);

  // High time, rounded half-up and kept strictly inside the period so the
  // output always toggles.
  localparam int HIGH_RAW = (PERIOD * DUTY + 50) / 100;
  localparam int HIGH     = (HIGH_RAW < 1) ? 1 :
                            ((HIGH_RAW > PERIOD - 1) ? PERIOD - 1 : HIGH_RAW);

  // One counter serves both the phase wait and the period position, so it
  // is sized for whichever of the two is longer.
  localparam int CNT_MAX = (PERIOD > PHASE) ? PERIOD : PHASE;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] HIGH_C   = CW'(HIGH);
  localparam logic [CW-1:0] PER_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] PH_LAST  = (PHASE > 0) ? CW'(PHASE - 1) : '0;

`ifdef CLOCK_GEN_GLITCHFREE_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   run_next;
  logic            clk_out_q, clk_out_d;
  logic            en_meta_q, en_s_q;

  // Two-flop synchronizer: en_s_q is the only view of enable the FSM uses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_meta_q <= 1'b0;
      en_s_q    <= 1'b0;
    end else begin
      en_meta_q <= enable;
      en_s_q    <= en_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
    end
  end

  // clk_out_d is derived from the counter value being loaded, so clk_out_q
  // lines up with cnt_q in the same cycle and is high on the very edge that
  // enters RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clk_out_d = 1'b0;
    run_next  = (cnt_q == PER_LAST) ? '0 : cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en_s_q) begin
          if (PHASE == 0) begin
            state_d   = ST_RUN;
            clk_out_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (!en_s_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == PH_LAST) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          clk_out_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef CLOCK_GEN_GLITCHFREE_EN
      // RUN and DRAIN count identically; they differ only in whether the
      // last cycle of a period with enable low ends the run. Enable coming
      // back during DRAIN just continues the period already in progress.
      ST_RUN, ST_DRAIN: begin
        if (!en_s_q && (cnt_q == PER_LAST)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          state_d   = en_s_q ? ST_RUN : ST_DRAIN;
          cnt_d     = run_next;
          clk_out_d = (run_next < HIGH_C);
        end
      end
`else
      ST_RUN: begin
        if (!en_s_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d     = run_next;
          clk_out_d = (run_next < HIGH_C);
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign clk_out      = clk_out_q;
  assign running      = (state_q != ST_IDLE);
  assign period_start = clk_out_q & (cnt_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_clock_gen.sv
// ============================================================================
// Module   : tb_clock_gen
// Purpose  : Randomized self-checking bench for clock_gen. Five instances
//            with different PERIOD/DUTY/PHASE share one enable/reset. A
//            reference model tracks, per instance, whether the generator is
//            on and how many reference cycles have elapsed since it started;
//            expected outputs follow from modular arithmetic on that time.
//            Honors CLOCK_GEN_GLITCHFREE_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_gen;

  localparam int N = 5;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic enable = 1'b0;

  logic [N-1:0] clk_out_w;
  logic [N-1:0] running_w;
  logic [N-1:0] ps_w;

  // Per-instance parameters and the high times the rounding rule gives.
  int P  [N] = '{10, 8, 4, 4, 8};
  int H  [N] = '{5, 2, 3, 1, 7};
  int PH [N] = '{0, 3, 0, 1, 0};

  // Model state: on/off and elapsed reference cycles since start.
  bit m_on [N];
  int m_t  [N];
  // Enable as sampled at the last two edges (oldest in s2).
  bit s1, s2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  clock_gen #(.PERIOD(10), .DUTY(50), .PHASE(0)) u0 (
    .clk(clk), .rst(rst), .enable(enable),
    .clk_out(clk_out_w[0]), .running(running_w[0]), .period_start(ps_w[0]));
  clock_gen #(.PERIOD(8), .DUTY(25), .PHASE(3)) u1 (
    .clk(clk), .rst(rst), .enable(enable),
    .clk_out(clk_out_w[1]), .running(running_w[1]), .period_start(ps_w[1]));
  clock_gen #(.PERIOD(4), .DUTY(99), .PHASE(0)) u2 (
    .clk(clk), .rst(rst), .enable(enable),
    .clk_out(clk_out_w[2]), .running(running_w[2]), .period_start(ps_w[2]));
  clock_gen #(.PERIOD(4), .DUTY(10), .PHASE(1)) u3 (
    .clk(clk), .rst(rst), .enable(enable),
    .clk_out(clk_out_w[3]), .running(running_w[3]), .period_start(ps_w[3]));
  clock_gen #(.PERIOD(8), .DUTY(90), .PHASE(0)) u4 (
    .clk(clk), .rst(rst), .enable(enable),
    .clk_out(clk_out_w[4]), .running(running_w[4]), .period_start(ps_w[4]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit exp_clk(input int i);
    return m_on[i] && (m_t[i] >= PH[i]) && (((m_t[i] - PH[i]) % P[i]) < H[i]);
  endfunction

  function automatic bit exp_ps(input int i);
    return m_on[i] && (m_t[i] >= PH[i]) && (((m_t[i] - PH[i]) % P[i]) == 0);
  endfunction

  // Advance one instance's model by one edge, given the synchronized enable.
  task automatic model_edge(input int i, input bit e);
    if (!m_on[i]) begin
      if (e) begin
        m_on[i] = 1'b1;
        m_t[i]  = 0;
      end
    end else begin
`ifdef CLOCK_GEN_GLITCHFREE_EN
      if (m_t[i] < PH[i]) begin
        if (!e) m_on[i] = 1'b0;
        else    m_t[i]++;
      end else if (!e && (((m_t[i] - PH[i]) % P[i]) == P[i] - 1)) begin
        m_on[i] = 1'b0;
      end else begin
        m_t[i]++;
      end
`else
      if (!e) m_on[i] = 1'b0;
      else    m_t[i]++;
`endif
      if (!m_on[i]) m_t[i] = 0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("clk_out[%0d]", i), clk_out_w[i], exp_clk(i));
      check($sformatf("running[%0d]", i), running_w[i], m_on[i]);
      check($sformatf("period_start[%0d]", i), ps_w[i], exp_ps(i));
    end
  endtask

  // One reference edge: update the model, then compare just after the edge.
  task automatic step();
    bit e;
    @(posedge clk);
    if (rst) begin
      s1 = 1'b0;
      s2 = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_on[i] = 1'b0;
        m_t[i]  = 0;
      end
    end else begin
      e  = s2;
      s2 = s1;
      s1 = enable;
      for (int i = 0; i < N; i++) model_edge(i, e);
    end
    #1;
    compare_all();
  endtask

  task automatic run(input bit en, input int n);
    @(negedge clk);
    enable = en;
    repeat (n) step();
  endtask

  initial begin
    int k;
    for (int i = 0; i < N; i++) begin
      m_on[i] = 1'b0;
      m_t[i]  = 0;
    end
    s1 = 1'b0;
    s2 = 1'b0;

    // Reset asserted before any clock edge must clear outputs on its own.
    #1 rst = 1'b1;
    #1;
    check("rst_clk_out", clk_out_w, 0);
    check("rst_running", running_w, 0);
    check("rst_period_start", ps_w, 0);
    repeat (3) step();
    @(negedge clk) rst = 1'b0;

    // Steady run, stop, restart (restart repeats any phase wait).
    run(1'b1, 60);
    run(1'b0, 20);
    run(1'b1, 30);

    // Asynchronous reset in the middle of a high phase of u0.
    k = 0;
    while (!(clk_out_w[0] == 1'b1 && exp_clk(0) && m_t[0] % P[0] == 1) && k < 50) begin
      step();
      k++;
    end
    check("wait_mid_high", clk_out_w[0], 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_clk_out", clk_out_w, 0);
    check("async_rst_running", running_w, 0);
    check("async_rst_period_start", ps_w, 0);
    repeat (2) step();
    @(negedge clk) rst = 1'b0;
    repeat (40) step();

    // Random enable levels with short holds, including one-cycle pulses.
    for (int r = 0; r < 40; r++)
      run(1'($urandom_range(0, 1)), $urandom_range(1, 30));

    // Ten toggles with long random holds.
    for (int r = 0; r < 10; r++)
      run(~enable, $urandom_range(1, 255));

    run(1'b0, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
